// File: rtl/reduce_or_sched.sv
// rtl/reduce_or_sched.sv - round-robin scheduler for a sliced, early-exit OR-reduction unit
module reduce_or_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 65,
    parameter int SLICE = 13,
    localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_or,
    output logic [SW-1:0]         rsp_slice,
    output logic                  busy
);
    localparam int PADW = NSLICE * SLICE;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_next;
    logic [IDW-1:0]     ptr;
    logic [SW-1:0]      slice_idx;
    logic [WIDTH-1:0]   operand;
    logic [PADW-1:0]    padded;
    logic [SLICE-1:0]   cur_slice;
    logic               hit;
    logic               last_slice;
    logic               gnt_found;
    logic [IDW-1:0]     gnt_idx;
    logic [NREQ-1:0]    gnt_onehot;
    logic [WIDTH-1:0]   gnt_data;
    int                 cand;

    // Search starts one past the last winner so every active source is reached within NREQ grants.
    always_comb begin
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        gnt_data   = '0;
        cand       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!gnt_found && j == cand && req_valid[j]) begin
                    gnt_found     = 1'b1;
                    gnt_idx       = IDW'(j);
                    gnt_onehot[j] = 1'b1;
                    gnt_data      = req_data[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Padding above WIDTH is forced to zero so the short last slice cannot false-hit.
    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = operand;
        cur_slice = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (slice_idx == SW'(s)) cur_slice = padded[s*SLICE +: SLICE];
        end
    end

    assign hit        = |cur_slice;
    assign last_slice = (slice_idx == SW'(NSLICE - 1));

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    state_next = SCAN;
                    req_ready  = gnt_onehot;
                end
            end
            SCAN: begin
                if (hit || last_slice) state_next = DONE;
            end
            DONE: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) req_ready = '0;
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            slice_idx <= '0;
            operand   <= '0;
            rsp_id    <= '0;
            rsp_or    <= 1'b0;
            rsp_slice <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        operand   <= gnt_data;
                        rsp_id    <= gnt_idx;
                        ptr       <= gnt_idx;
                        slice_idx <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        rsp_or    <= 1'b1;
                        rsp_slice <= slice_idx;
                    end else if (last_slice) begin
                        rsp_or    <= 1'b0;
                        rsp_slice <= '0;
                    end else begin
                        slice_idx <= slice_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reduce_or_sched.sv
// tb/tb_reduce_or_sched.sv - directed self-checking bench for reduce_or_sched
module tb_reduce_or_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 65;
    localparam int SLICE = 13;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [1:0]            rsp_id;
    logic                  rsp_or;
    logic [2:0]            rsp_slice;
    logic                  busy;

    logic [1:0]            req_valid2 = '0;
    logic [2*WIDTH-1:0]    req_data2 = '0;
    logic [1:0]            req_ready2;
    logic                  rsp_valid2;
    logic                  rsp_ready2 = 1'b1;
    logic [0:0]            rsp_id2;
    logic                  rsp_or2;
    logic [2:0]            rsp_slice2;
    logic                  busy2;

    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    reduce_or_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_or(rsp_or), .rsp_slice(rsp_slice), .busy(busy)
    );

    reduce_or_sched #(.NREQ(2), .WIDTH(WIDTH), .SLICE(16)) dut16 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_id(rsp_id2), .rsp_or(rsp_or2), .rsp_slice(rsp_slice2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Grants must be one-hot and never overlap a transaction in flight.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(req_ready) > 1 || (|req_ready && busy)) begin
                failures++;
                $display("FAIL grant_invariant req_ready=%b busy=%b required one-hot and idle", req_ready, busy);
            end
        end
    end

    task automatic apply_reset;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; req_valid2 = '0; rsp_ready = 1'b0; req_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 65'd1 << i;
        @(posedge clk); mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold ready=%b valid=%b busy=%b required 0000/0/0", req_ready, rsp_valid, busy);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL first_grant got=%b required 0001", req_ready);
        end
    endtask

    task automatic test_latency;
        int ids [5];
        logic [WIDTH-1:0] datas [5];
        int lats [5];
        logic ors [5];
        logic [2:0] slices [5];
        logic [3:0] exp_rdy;
        int lat;
        ids[0] = 0; datas[0] = 65'd1;        lats[0] = 2; ors[0] = 1'b1; slices[0] = 3'd0;
        ids[1] = 1; datas[1] = 65'd1 << 64;  lats[1] = 6; ors[1] = 1'b1; slices[1] = 3'd4;
        ids[2] = 2; datas[2] = 65'd0;        lats[2] = 6; ors[2] = 1'b0; slices[2] = 3'd0;
        ids[3] = 3; datas[3] = 65'd1 << 52;  lats[3] = 6; ors[3] = 1'b1; slices[3] = 3'd4;
        ids[4] = 0; datas[4] = 65'd1 << 25;  lats[4] = 3; ors[4] = 1'b1; slices[4] = 3'd1;
        for (int v = 0; v < 5; v++) begin
            apply_reset();
            req_data = '0;
            req_data[ids[v]*WIDTH +: WIDTH] = datas[v];
            exp_rdy = 4'b0001 << ids[v];
            req_valid = exp_rdy;
            rsp_ready = 1'b1;
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL lat_grant[%0d] got=%b required %b", v, req_ready, exp_rdy);
            end
            @(posedge clk); #1;
            req_valid = '0;
            lat = 1;
            while (rsp_valid !== 1'b1 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== lats[v]) begin
                failures++;
                $display("FAIL lat_cycles[%0d] got=%0d required %0d", v, lat, lats[v]);
            end
            checks++;
            if (rsp_or !== ors[v] || rsp_slice !== slices[v] || rsp_id !== 2'(ids[v])) begin
                failures++;
                $display("FAIL lat_result[%0d] or/slice/id got=%b/%0d/%0d required %b/%0d/%0d",
                         v, rsp_or, rsp_slice, rsp_id, ors[v], slices[v], ids[v]);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL lat_release[%0d] valid=%b busy=%b required 0/0", v, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_partial_slice;
        logic [WIDTH-1:0] datas [2];
        int lats [2];
        logic [2:0] slices [2];
        int lat;
        datas[0] = 65'd1 << 64; lats[0] = 6; slices[0] = 3'd4;
        datas[1] = 65'd1 << 63; lats[1] = 5; slices[1] = 3'd3;
        for (int v = 0; v < 2; v++) begin
            apply_reset();
            req_data2 = '0;
            req_data2[WIDTH-1:0] = datas[v];
            req_valid2 = 2'b01;
            rsp_ready2 = 1'b1;
            @(posedge clk); #1;
            req_valid2 = '0;
            lat = 1;
            while (rsp_valid2 !== 1'b1 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== lats[v] || rsp_or2 !== 1'b1 || rsp_slice2 !== slices[v]) begin
                failures++;
                $display("FAIL slice16[%0d] lat/or/slice got=%0d/%b/%0d required %0d/1/%0d",
                         v, lat, rsp_or2, rsp_slice2, lats[v], slices[v]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fairness;
        int order [6];
        int n, cyc, last, g;
        order = '{0, 1, 2, 3, 0, 1};
        apply_reset();
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 65'd1 << i;
        req_valid = '1;
        rsp_ready = 1'b1;
        n = 0; cyc = 0; last = 0; g = 0;
        while (n < 6 && cyc < 100) begin
            #1;
            if (|req_ready) begin
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) g = j;
                checks++;
                if (g !== order[n]) begin
                    failures++;
                    $display("FAIL fair_order[%0d] got=%0d required %0d", n, g, order[n]);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last !== 3) begin
                        failures++;
                        $display("FAIL fair_spacing[%0d] got=%0d required 3", n, cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (n !== 6) begin
            failures++;
            $display("FAIL fair_timeout grants=%0d required 6", n);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        int waitc;
        apply_reset();
        req_data[0 +: WIDTH] = 65'd1 << 20;
        req_data[1*WIDTH +: WIDTH] = 65'd1;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b1110;
        waitc = 0;
        while (rsp_valid !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_timeout rsp_valid=%b required 1", rsp_valid);
        end
        repeat (10) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_or !== 1'b1 || rsp_slice !== 3'd1 || req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold valid/id/or/slice/ready got=%b/%0d/%b/%0d/%b required 1/0/1/1/0000",
                         rsp_valid, rsp_id, rsp_or, rsp_slice, req_ready);
            end
        end
        rsp_ready = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_handshake_ready got=%b required 0000", req_ready);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0; #1;
        checks++;
        if (req_ready !== 4'b0010 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_grant ready=%b busy=%b required 0010/0", req_ready, busy);
        end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic test_reset_mid;
        apply_reset();
        req_data[0 +: WIDTH] = 65'd1 << 64;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_grant got=%b required 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'b1100;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_reset ready=%b busy=%b valid=%b required 0000/1/0", req_ready, busy, rsp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL mid_after_reset busy=%b valid=%b ready=%b required 0/0/0100", busy, rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_partial_slice();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        apply_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
